// File: rtl/control_multi_pkg.sv
// control_multi_pkg: shared opcodes, select encodings, state and class types for the multicycle LEGv8 control unit.
// Rev 1.0. Optional MEM_TIMEOUT_EN adds the FAULT state encoding.
`default_nettype none

package control_multi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_ALU_WB   = 4'd5,
    ST_MEMADDR  = 4'd6,
    ST_MEMREAD  = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEMWRITE = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
`ifdef MEM_TIMEOUT_EN
    , ST_FAULT  = 4'd12
`endif
  } state_e;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_CB      = 3'd4,
    CLS_BCOND   = 3'd5,
    CLS_B       = 3'd6,
    CLS_ILLEGAL = 3'd7
  } opc_class_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ORIGB_REG2  = 2'b00;
  localparam logic [1:0] ORIGB_FOUR  = 2'b01;
  localparam logic [1:0] ORIGB_IMM   = 2'b10;
  localparam logic [1:0] ORIGB_BROFF = 2'b11;

  localparam logic [1:0] ORIGPC_ALU    = 2'b00;
  localparam logic [1:0] ORIGPC_ALUOUT = 2'b01;
  localparam logic [1:0] ORIGPC_JUMP   = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_CB   = 2'b01;
  localparam logic [1:0] BR_COND = 2'b10;

  // '?' marks immediate/offset bits that sit inside the 11-bit opcode field
  localparam logic [10:0] OPC_ADD    = 11'b10001011000;
  localparam logic [10:0] OPC_ADDS   = 11'b10101011000;
  localparam logic [10:0] OPC_SUB    = 11'b11001011000;
  localparam logic [10:0] OPC_SUBS   = 11'b11101011000;
  localparam logic [10:0] OPC_AND    = 11'b10001010000;
  localparam logic [10:0] OPC_ANDS   = 11'b11101010000;
  localparam logic [10:0] OPC_ORR    = 11'b10101010000;
  localparam logic [10:0] OPC_EOR    = 11'b11001010000;
  localparam logic [10:0] OPC_LSL    = 11'b11010011011;
  localparam logic [10:0] OPC_LSR    = 11'b11010011010;
  localparam logic [10:0] OPC_ADDI   = 11'b1001000100?;
  localparam logic [10:0] OPC_ADDIS  = 11'b1011000100?;
  localparam logic [10:0] OPC_SUBI   = 11'b1101000100?;
  localparam logic [10:0] OPC_SUBIS  = 11'b1111000100?;
  localparam logic [10:0] OPC_ANDI   = 11'b1001001000?;
  localparam logic [10:0] OPC_ANDIS  = 11'b1111001000?;
  localparam logic [10:0] OPC_ORRI   = 11'b1011001000?;
  localparam logic [10:0] OPC_EORI   = 11'b1101001000?;
  localparam logic [10:0] OPC_LDUR   = 11'b11111000010;
  localparam logic [10:0] OPC_LDURSW = 11'b10111000100;
  localparam logic [10:0] OPC_LDURH  = 11'b01111000010;
  localparam logic [10:0] OPC_LDURB  = 11'b00111000010;
  localparam logic [10:0] OPC_STUR   = 11'b11111000000;
  localparam logic [10:0] OPC_STURW  = 11'b10111000000;
  localparam logic [10:0] OPC_STURH  = 11'b01111000000;
  localparam logic [10:0] OPC_STURB  = 11'b00111000000;
  localparam logic [10:0] OPC_CBZ    = 11'b10110100???;
  localparam logic [10:0] OPC_CBNZ   = 11'b10110101???;
  localparam logic [10:0] OPC_BCOND  = 11'b01010100???;
  localparam logic [10:0] OPC_B      = 11'b000101?????;

endpackage

`default_nettype wire

// File: rtl/control_multi_opc_class_dec.sv
// opc_class_dec: combinational classification of the 11-bit LEGv8 opcode field.
// Rev 1.0.
`default_nettype none

module opc_class_dec
  import control_multi_pkg::*;
(
  input  logic [10:0] iOPCODE,
  output opc_class_e  oClass
);

  always_comb begin
    oClass = CLS_ILLEGAL;
    casez (iOPCODE)
      OPC_ADD, OPC_ADDS, OPC_SUB, OPC_SUBS,
      OPC_AND, OPC_ANDS, OPC_ORR, OPC_EOR,
      OPC_LSL, OPC_LSR:                        oClass = CLS_R;
      OPC_ADDI, OPC_ADDIS, OPC_SUBI, OPC_SUBIS,
      OPC_ANDI, OPC_ANDIS, OPC_ORRI, OPC_EORI: oClass = CLS_I;
      OPC_LDUR, OPC_LDURSW, OPC_LDURH,
      OPC_LDURB:                               oClass = CLS_LOAD;
      OPC_STUR, OPC_STURW, OPC_STURH,
      OPC_STURB:                               oClass = CLS_STORE;
      OPC_CBZ, OPC_CBNZ:                       oClass = CLS_CB;
      OPC_BCOND:                               oClass = CLS_BCOND;
      OPC_B:                                   oClass = CLS_B;
      default:                                 oClass = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_multi.sv
// control_multi: multicycle LEGv8 control FSM driving the shared-datapath selects and enables.
// Rev 1.0. Define MEM_TIMEOUT_EN for the memory-wait watchdog, FAULT state and oMemFault port.
`default_nettype none

module control_multi
  import control_multi_pkg::*;
#(
  parameter int OPC_W = 11,
  parameter int ST_W  = 4
`ifdef MEM_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 16
`endif
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [OPC_W-1:0] iOPCODE,
  input  logic             iMemReady,
  output logic             oIorD,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oIRWrite,
  output logic             oPCWrite,
  output logic             oPCWriteCond,
  output logic [1:0]       oOrigPC,
  output logic             oOrigAULA,
  output logic [1:0]       oOrigBULA,
  output logic [1:0]       oALUop,
  output logic             oReg2Loc,
  output logic [1:0]       oBranch,
  output logic             oMemToReg,
  output logic             oRegWrite,
  output logic             oRetire,
  output logic             oIllegal,
  output logic [ST_W-1:0]  oState
`ifdef MEM_TIMEOUT_EN
  , output logic           oMemFault
`endif
);

  state_e     state_q, state_d;
  opc_class_e cls;
  logic       w_reg2loc;

  opc_class_dec u_dec (
    .iOPCODE (iOPCODE[10:0]),
    .oClass  (cls)
  );

  assign w_reg2loc = (cls == CLS_STORE) || (cls == CLS_CB);
  assign oState    = ST_W'(state_q);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q;
  logic             w_wait;

  assign w_wait    = (state_q == ST_FETCH) || (state_q == ST_MEMREAD) || (state_q == ST_MEMWRITE);
  assign oMemFault = fault_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_q | (state_d == ST_FAULT);
    end
  end
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    oIorD        = 1'b0;
    oMemRead     = 1'b0;
    oMemWrite    = 1'b0;
    oIRWrite     = 1'b0;
    oPCWrite     = 1'b0;
    oPCWriteCond = 1'b0;
    oOrigPC      = ORIGPC_ALU;
    oOrigAULA    = 1'b0;
    oOrigBULA    = ORIGB_REG2;
    oALUop       = ALUOP_ADD;
    oReg2Loc     = 1'b0;
    oBranch      = BR_NONE;
    oMemToReg    = 1'b0;
    oRegWrite    = 1'b0;
    oRetire      = 1'b0;
    oIllegal     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        oMemRead  = 1'b1;
        oOrigBULA = ORIGB_FOUR;
        if (iMemReady) begin
          oIRWrite = 1'b1;
          oPCWrite = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // ALU computes PC + branch offset now so BRANCH can take it from ALUOut
        oOrigBULA = ORIGB_BROFF;
        oReg2Loc  = w_reg2loc;
        case (cls)
          CLS_R:               state_d = ST_EXEC_R;
          CLS_I:               state_d = ST_EXEC_I;
          CLS_LOAD, CLS_STORE: state_d = ST_MEMADDR;
          CLS_CB, CLS_BCOND:   state_d = ST_BRANCH;
          CLS_B:               state_d = ST_JUMP;
          default: begin
            oIllegal = 1'b1;
            state_d  = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R: begin
        oOrigAULA = 1'b1;
        oOrigBULA = ORIGB_REG2;
        oALUop    = ALUOP_FUNCT;
        state_d   = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        oOrigAULA = 1'b1;
        oOrigBULA = ORIGB_IMM;
        oALUop    = ALUOP_FUNCT;
        state_d   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        oRegWrite = 1'b1;
        oRetire   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEMADDR: begin
        oOrigAULA = 1'b1;
        oOrigBULA = ORIGB_IMM;
        oReg2Loc  = w_reg2loc;
        state_d   = (cls == CLS_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
        if (iMemReady) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        oRegWrite = 1'b1;
        oMemToReg = 1'b1;
        oRetire   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEMWRITE: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        oReg2Loc  = 1'b1;
        if (iMemReady) begin
          oRetire = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        oOrigAULA    = 1'b1;
        oOrigBULA    = ORIGB_REG2;
        oReg2Loc     = 1'b1;
        oALUop       = ALUOP_PASS;
        oPCWriteCond = 1'b1;
        oOrigPC      = ORIGPC_ALUOUT;
        oBranch      = (cls == CLS_BCOND) ? BR_COND : BR_CB;
        oRetire      = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_JUMP: begin
        oPCWrite = 1'b1;
        oOrigPC  = ORIGPC_JUMP;
        oRetire  = 1'b1;
        state_d  = ST_FETCH;
      end
`ifdef MEM_TIMEOUT_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    // Count restarts at zero whenever a wait state is entered or left
    cnt_d = '0;
    if (w_wait && !iMemReady) begin
      if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = ST_FAULT;
      else                                  cnt_d   = cnt_q + CNT_W'(1);
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_control_multi.sv
// tb_control_multi: random instruction stream checked against a per-instruction expected-trace model.
// Rev 1.0. Compile with MEM_TIMEOUT_EN to include the watchdog scenario.
`default_nettype none

module tb_control_multi;
  import control_multi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] opcode = '0;
  logic        mem_ready = 1'b0;
  logic        iord, mrd, mwr, irw, pcw, pcwc, oa, r2l, m2r, rw, ret, ill;
  logic [1:0]  opc, ob, aop, br;
  logic [3:0]  st;
`ifdef MEM_TIMEOUT_EN
  logic        mem_fault;
`endif

  always #5 clk = ~clk;

  control_multi dut (
    .iCLK(clk), .iRST(rst), .iOPCODE(opcode), .iMemReady(mem_ready),
    .oIorD(iord), .oMemRead(mrd), .oMemWrite(mwr), .oIRWrite(irw),
    .oPCWrite(pcw), .oPCWriteCond(pcwc), .oOrigPC(opc), .oOrigAULA(oa),
    .oOrigBULA(ob), .oALUop(aop), .oReg2Loc(r2l), .oBranch(br),
    .oMemToReg(m2r), .oRegWrite(rw), .oRetire(ret), .oIllegal(ill),
    .oState(st)
`ifdef MEM_TIMEOUT_EN
    , .oMemFault(mem_fault)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic iord, mrd, mwr, irw, pcw, pcwc;
    logic [1:0] opc;
    logic oa;
    logic [1:0] ob, aop;
    logic r2l;
    logic [1:0] br;
    logic m2r, rw, ret, ill;
  } exp_t;

  typedef struct {
    logic rdy;
    exp_t e;
  } cyc_t;

  cyc_t trace[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cyc = 0;

  task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = '{st:st, iord:iord, mrd:mrd, mwr:mwr, irw:irw, pcw:pcw, pcwc:pcwc, opc:opc,
          oa:oa, ob:ob, aop:aop, r2l:r2l, br:br, m2r:m2r, rw:rw, ret:ret, ill:ill};
    return o;
  endfunction

  function automatic exp_t blank(input logic [3:0] s);
    exp_t e;
    e    = '0;
    e.st = s;
    return e;
  endfunction

  task automatic push(input logic rdy, input exp_t e);
    cyc_t c;
    c.rdy = rdy;
    c.e   = e;
    trace.push_back(c);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle trace of one instruction, built from its class and memory latencies
  task automatic gen_instr(input opc_class_e c, input int fw, input int mw);
    exp_t e;
    for (int i = 0; i <= fw; i++) begin
      e = blank(ST_FETCH); e.mrd = 1; e.ob = 2'b01;
      if (i == fw) begin e.irw = 1; e.pcw = 1; end
      push(i == fw, e);
    end
    e = blank(ST_DECODE); e.ob = 2'b11;
    e.r2l = (c == CLS_STORE) || (c == CLS_CB);
    e.ill = (c == CLS_ILLEGAL);
    push(rnd_bit(), e);
    case (c)
      CLS_R, CLS_I: begin
        e = blank(c == CLS_R ? ST_EXEC_R : ST_EXEC_I);
        e.oa = 1; e.ob = (c == CLS_R) ? 2'b00 : 2'b10; e.aop = 2'b10;
        push(rnd_bit(), e);
        e = blank(ST_ALU_WB); e.rw = 1; e.ret = 1;
        push(rnd_bit(), e);
      end
      CLS_LOAD: begin
        e = blank(ST_MEMADDR); e.oa = 1; e.ob = 2'b10;
        push(rnd_bit(), e);
        for (int i = 0; i <= mw; i++) begin
          e = blank(ST_MEMREAD); e.mrd = 1; e.iord = 1;
          push(i == mw, e);
        end
        e = blank(ST_MEM_WB); e.rw = 1; e.m2r = 1; e.ret = 1;
        push(rnd_bit(), e);
      end
      CLS_STORE: begin
        e = blank(ST_MEMADDR); e.oa = 1; e.ob = 2'b10; e.r2l = 1;
        push(rnd_bit(), e);
        for (int i = 0; i <= mw; i++) begin
          e = blank(ST_MEMWRITE); e.mwr = 1; e.iord = 1; e.r2l = 1; e.ret = (i == mw);
          push(i == mw, e);
        end
      end
      CLS_CB, CLS_BCOND: begin
        e = blank(ST_BRANCH); e.oa = 1; e.r2l = 1; e.aop = 2'b01; e.pcwc = 1;
        e.opc = 2'b01; e.br = (c == CLS_CB) ? 2'b01 : 2'b10; e.ret = 1;
        push(rnd_bit(), e);
      end
      CLS_B: begin
        e = blank(ST_JUMP); e.pcw = 1; e.opc = 2'b10; e.ret = 1;
        push(rnd_bit(), e);
      end
      default: ;
    endcase
  endtask

  // Apply the first 'limit' trace entries; the opcode changes with the first FETCH cycle
  task automatic run(input logic [10:0] op, input int limit);
    cyc_t c;
    for (int i = 0; i < limit && trace.size() > 0; i++) begin
      c = trace.pop_front();
      @(negedge clk);
      if (i == 0) opcode = op;
      mem_ready = c.rdy;
      #1;
      n_cyc++;
      check_val($sformatf("cyc%0d op%b st%0d", n_cyc, op, c.e.st), observed(), c.e);
    end
  endtask

  task automatic do_instr(input logic [10:0] op, input opc_class_e c, input int fw, input int mw);
    trace.delete();
    gen_instr(c, fw, mw);
    run(op, trace.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = rnd_bit();
    #1;
    check_val("reset_asserted", observed(), blank(ST_IDLE));
`ifdef MEM_TIMEOUT_EN
    check_val("reset_fault", 24'(mem_fault), 24'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset_idle", observed(), blank(ST_IDLE));
  endtask

  task automatic pick(input int k, output logic [10:0] op, output opc_class_e c);
    logic [10:0] base, mask;
    mask = '0;
    case (k)
      0:  begin base = 11'b10001011000; c = CLS_R; end
      1:  begin base = 11'b11001011000; c = CLS_R; end
      2:  begin base = 11'b10101010000; c = CLS_R; end
      3:  begin base = 11'b11010011011; c = CLS_R; end
      4:  begin base = 11'b10010001000; mask = 11'h001; c = CLS_I; end
      5:  begin base = 11'b11110001000; mask = 11'h001; c = CLS_I; end
      6:  begin base = 11'b11010010000; mask = 11'h001; c = CLS_I; end
      7:  begin base = 11'b11111000010; c = CLS_LOAD; end
      8:  begin base = 11'b00111000010; c = CLS_LOAD; end
      9:  begin base = 11'b11111000000; c = CLS_STORE; end
      10: begin base = 11'b10111000000; c = CLS_STORE; end
      11: begin base = 11'b10110100000; mask = 11'h007; c = CLS_CB; end
      12: begin base = 11'b10110101000; mask = 11'h007; c = CLS_CB; end
      13: begin base = 11'b01010100000; mask = 11'h007; c = CLS_BCOND; end
      14: begin base = 11'b00010100000; mask = 11'h01F; c = CLS_B; end
      15: begin base = 11'b00000000000; c = CLS_ILLEGAL; end
      16: begin base = 11'b11111111111; c = CLS_ILLEGAL; end
      default: begin base = 11'b10010100000; mask = 11'h01F; c = CLS_ILLEGAL; end
    endcase
    op = base | (11'($urandom) & mask);
  endtask

  initial begin
    logic [10:0] op;
    opc_class_e  c;

    repeat (2) @(posedge clk);
    do_reset();

    do_instr(11'b10001011000, CLS_R, 0, 0);
    do_instr(11'b11111000010, CLS_LOAD, 3, 2);
    do_instr(11'b11111000000, CLS_STORE, 1, 3);
    do_instr(11'b10110100101, CLS_CB, 0, 0);
    do_instr(11'b01010100011, CLS_BCOND, 0, 0);
    do_instr(11'b00010110110, CLS_B, 0, 0);
    do_instr(11'b00000000000, CLS_ILLEGAL, 0, 0);

    // Abandon a load in its first MEMREAD wait cycle
    trace.delete();
    gen_instr(CLS_LOAD, 1, 4);
    run(11'b11111000010, 5);
    trace.delete();
    do_reset();

    for (int n = 0; n < 60; n++) begin
      pick($urandom_range(0, 17), op, c);
      do_instr(op, c, $urandom_range(0, 5), $urandom_range(0, 5));
    end

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check_val($sformatf("to_fetch%0d", i), 24'(st), 24'(ST_FETCH));
      check_val($sformatf("to_nofault%0d", i), 24'(mem_fault), 24'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = rnd_bit();
      #1;
      check_val($sformatf("to_state%0d", i), observed(), blank(ST_FAULT));
      check_val($sformatf("to_fault%0d", i), 24'(mem_fault), 24'd1);
    end
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_multi.md
Name: control_multi

Overview:
- Multicycle LEGv8 control unit: a Moore/Mealy FSM that sequences the shared datapath (single memory, ALU, register bank, PC/IR/ALUOut registers) one instruction at a time.
- Sits beside the multicycle datapath and drives its mux selects and write enables.
- Reads the 11-bit opcode from the instruction register and handshakes with memory through a ready strobe.

Parameters:
- OPC_W, 11, opcode width.
- ST_W, 4, state register width.
- MEM_TIMEOUT, 16, max wait cycles for iMemReady (used only with MEM_TIMEOUT_EN).

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iOPCODE  in  11  IR[31:21]; valid and stable from DECODE until the next FETCH completes.
- iMemReady  in  1  memory access complete this cycle.
- oIorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- oMemRead, oMemWrite  out  1 each  memory strobes.
- oIRWrite, oPCWrite, oPCWriteCond  out  1 each  register enables.
- oOrigPC  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- oOrigAULA  out  1  ALU A select: 0 = PC, 1 = register 1.
- oOrigBULA  out  2  ALU B select: 00 = register 2, 01 = const 4, 10 = sign-extended immediate, 11 = shifted branch offset.
- oALUop  out  2  00 = add, 01 = pass/compare, 10 = funct-decoded.
- oReg2Loc  out  1  0 = Rm, 1 = Rt.
- oBranch  out  2  00 = none, 01 = CBZ/CBNZ, 10 = B.cond.
- oMemToReg, oRegWrite  out  1 each  writeback controls.
- oRetire  out  1  one-cycle pulse when an instruction completes.
- oIllegal  out  1  one-cycle pulse when the opcode is undecodable.
- oState  out  4  current state, for debug.

Behaviour:
- Reset: state is IDLE; every output is 0, including the state encoding.
- IDLE goes unconditionally to FETCH on the next edge.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Asserts MemRead=1, IorD=0, OrigAULA=0, OrigBULA=01, ALUop=00, OrigPC=00.
  - IRWrite and PCWrite are asserted only in the cycle iMemReady=1 (Mealy); that cycle also moves to DECODE.
  - Otherwise stays in FETCH.
- DECODE:
  - Asserts OrigAULA=0, OrigBULA=11, ALUop=00, so ALUOut holds the branch target.
  - Reg2Loc=1 when the opcode is STUR-class or CB-class.
  - Dispatch:
    - R-class goes to EXEC_R.
    - ADDI/SUBI/ANDI/ORRI/EORI and their flag-setting forms go to EXEC_I.
    - LDUR*/STUR* goes to MEMADDR.
    - CBZ/CBNZ/B.cond goes to BRANCH.
    - B goes to JUMP.
    - Anything else pulses oIllegal and goes to FETCH, with no retire.
- EXEC_R: OrigAULA=1, OrigBULA=00, ALUop=10; next state ALU_WB.
- EXEC_I: OrigAULA=1, OrigBULA=10, ALUop=10; next state ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0, oRetire=1; next state FETCH.
- MEMADDR: OrigAULA=1, OrigBULA=10, ALUop=00, Reg2Loc as in DECODE; next state MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: MemRead=1, IorD=1; waits for iMemReady, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, oRetire=1; next state FETCH.
- MEMWRITE:
  - MemWrite=1, IorD=1, Reg2Loc=1.
  - On iMemReady, pulses oRetire and goes to FETCH.
  - Strobes are held while waiting.
- BRANCH:
  - OrigAULA=1, OrigBULA=00, Reg2Loc=1, ALUop=01, PCWriteCond=1, OrigPC=01.
  - oBranch=01 for CBZ/CBNZ, 10 for B.cond.
  - oRetire=1; next state FETCH.
- JUMP: PCWrite=1, OrigPC=10, oRetire=1; next state FETCH.
- CPI: R/I = 4, load = 5, store = 4, branch/jump = 3, each plus memory wait cycles.
- Boundaries:
  - iMemReady outside FETCH/MEMREAD/MEMWRITE is ignored.
  - iRST mid-instruction returns to IDLE immediately; outputs are 0 while reset is asserted; the partial instruction is abandoned with no retire.
  - Unreachable state encodings go to IDLE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Adds a wait counter, cleared on entry to FETCH/MEMREAD/MEMWRITE and incremented each cycle without iMemReady.
  - When the count reaches MEM_TIMEOUT, goes to a FAULT state with all strobes 0 and adds port oMemFault (1 bit, sticky until iRST).
  - FAULT is exited only by reset.
- Undefined: no counter, no FAULT state, no oMemFault port; waits are unbounded.

Decomposition:
- Shared parameters header (the existing include-guarded header) holds:
  - OPC_* opcode constants.
  - ALUop codes.
  - OrigBULA/OrigPC select encodings.
  - ST_* state encodings.
- One natural sub-module, opc_class_dec: combinational casez from iOPCODE to a 3-bit class {R, I, LOAD, STORE, CB, BCOND, B, ILLEGAL}.

Test Plan:
- ADD (10001011000), iMemReady=1 always -> states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite=1 in cycle 4; oRetire once.
- LDUR (11111000010), FETCH ready after 3 wait cycles, MEMREAD ready after 2 -> IRWrite only on the ready cycle; MemToReg=1 and RegWrite=1 in MEM_WB; total 10 cycles.
- STUR (11111000000) -> MemWrite and IorD held until ready; RegWrite never 1; Reg2Loc=1 in MEMADDR and MEMWRITE.
- CBZ (10110100xxx) -> PCWriteCond=1, oBranch=01, OrigPC=01 in BRANCH; B.cond (01010100xxx) -> oBranch=10; B (000101xxxxx) -> PCWrite=1, OrigPC=10.
- Opcode 00000000000 -> oIllegal pulse in DECODE, no oRetire; iRST asserted during MEMREAD -> oState=0 and all outputs 0 immediately.
- With MEM_TIMEOUT_EN, iMemReady held 0 in FETCH -> oMemFault=1 after 16 cycles, sticky until reset.
